// File: rtl/apb_modport_pkg.sv
// Shared constants and FSM state type for the zero-wait-state APB register-file slave.
package apb_modport_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;
endpackage

// File: rtl/apb_modport_mem.sv
// Register file: synchronous write, registered read port, whole array cleared on reset.
// Latency: read data appears one cycle after re_i; holds its value when re_i is low.
module apb_modport_mem #(
    parameter int ADDR_W = apb_modport_pkg::ADDR_W,
    parameter int DATA_W = apb_modport_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // rst_n is active-high: the array is zeroed on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[waddr_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/apb_modport.sv
// Zero-wait-state APB slave over a 2**ADDR_W x DATA_W register file; pready is a one-cycle pulse per transfer.
// Optional assertions compiled in with APB_MODPORT_SVA_EN.
module apb_modport #(
    parameter int ADDR_W = apb_modport_pkg::ADDR_W,
    parameter int DATA_W = apb_modport_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready
);
    import apb_modport_pkg::*;

    // state_d is the bus phase of the current cycle, state_q that of the previous cycle.
    apb_state_e state_q, state_d;
    logic       pready_q, pready_d;
    logic       mem_we, mem_re;

    always_comb begin
        state_d  = IDLE;
        pready_d = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        case (state_q)
            SETUP:   state_d = ACCESS;
            default: state_d = (psel && !penable) ? SETUP : IDLE;
        endcase
        // A dropped psel in ACCESS still gets its pready pulse, but the write is suppressed.
        mem_we   = (state_d == ACCESS) && psel && penable && pwrite;
        mem_re   = (state_d == SETUP) && !pwrite;
        pready_d = (state_d == SETUP);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q  <= IDLE;
            pready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pready_q <= pready_d;
        end
    end

    apb_modport_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .waddr_i (paddr),
        .wdata_i (pwdata),
        .re_i    (mem_re),
        .raddr_i (paddr),
        .rdata_o (prdata)
    );

    assign pready = pready_q;

`ifdef APB_MODPORT_SVA_EN
    a_pready_pulse: assert property (@(posedge clk) disable iff (rst_n)
        pready_q |=> !pready_q);
    a_pready_penable: assert property (@(posedge clk) disable iff (rst_n)
        pready_q |-> penable);
    a_access_stable: assert property (@(posedge clk) disable iff (rst_n)
        (state_d == ACCESS && psel) |-> ($stable(paddr) && $stable(pwrite) && $stable(pwdata)));
    a_no_x_ctrl: assert property (@(posedge clk)
        !$isunknown(psel) && !$isunknown(rst_n));
`endif
endmodule

// File: tb/tb_apb_modport.sv
// Self-checking bench for apb_modport: randomized and directed APB transfers against an array model.
module tb_apb_modport;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [7:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready;

    logic [31:0] model [256];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    apb_modport #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model[i] = '0;
    endtask

    // Drives one setup+access pair; called #1 after a rising edge, returns #1 after the post-access edge.
    // hs is the observed pready pattern {setup, access, after}; the caller compares it to 3'b010.
    task automatic xfer(input bit wr, input logic [7:0] a, input logic [31:0] d, input bit keep,
                        output logic [2:0] hs, output logic [31:0] rd);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        hs[2] = pready;
        step();
        penable = 1'b1;
        hs[1] = pready;
        rd = prdata;
        step();
        hs[0] = pready;
        if (!keep) begin
            psel = 1'b0; penable = 1'b0;
        end
        if (wr) model[a] = d;
    endtask

    task automatic test_reset();
        logic [2:0]  hs;
        logic [31:0] rd;
        rst_n = 1'b1;
        step(); step();
        n_checks++;
        if (pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready: got %b expected 0", pready); end
        n_checks++;
        if (prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata: got %h expected 0", prdata); end
        rst_n = 1'b0;
        model_clear();
        step();
        xfer(1'b0, 8'h10, 32'h0, 1'b0, hs, rd);
        n_checks++;
        if (hs !== 3'b010) begin n_fail++; $display("FAIL reset_read_hs: got %b expected 010", hs); end
        n_checks++;
        if (rd !== model[8'h10]) begin n_fail++; $display("FAIL reset_read_data: got %h expected %h", rd, model[8'h10]); end
    endtask

    task automatic test_write_read();
        logic [2:0]  hs;
        logic [31:0] rd;
        xfer(1'b1, 8'h05, 32'hDEAD_BEEF, 1'b0, hs, rd);
        n_checks++;
        if (hs !== 3'b010) begin n_fail++; $display("FAIL wr_hs: got %b expected 010", hs); end
        xfer(1'b0, 8'h05, 32'h0, 1'b0, hs, rd);
        n_checks++;
        if (hs !== 3'b010) begin n_fail++; $display("FAIL rd_hs: got %b expected 010", hs); end
        n_checks++;
        if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  hs;
        logic [31:0] rd;
        logic [7:0]  addrs [4];
        logic [31:0] exp  [4];
        bit          wrs  [4];
        addrs = '{8'h01, 8'hFF, 8'h01, 8'hFF};
        exp   = '{32'h1111_1111, 32'h2222_2222, 32'h1111_1111, 32'h2222_2222};
        wrs   = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            xfer(wrs[i], addrs[i], exp[i], i != 3, hs, rd);
            n_checks++;
            if (hs !== 3'b010) begin n_fail++; $display("FAIL b2b_hs[%0d]: got %b expected 010", i, hs); end
            if (!wrs[i]) begin
                n_checks++;
                if (rd !== exp[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rd, exp[i]); end
            end
        end
    endtask

    task automatic test_sweep();
        logic [2:0]  hs;
        logic [31:0] rd;
        for (int a = 1; a < 256; a++) begin
            xfer(1'b1, a[7:0], 32'(a), 1'b1, hs, rd);
            n_checks++;
            if (hs !== 3'b010) begin n_fail++; $display("FAIL sweep_wr_hs[%0d]: got %b expected 010", a, hs); end
        end
        for (int a = 1; a < 256; a++) begin
            xfer(1'b0, a[7:0], 32'h0, a != 255, hs, rd);
            n_checks++;
            if (rd !== 32'(a) || hs !== 3'b010) begin
                n_fail++;
                $display("FAIL sweep_rd[%0d]: got data %h hs %b expected data %h hs 010", a, rd, hs, 32'(a));
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  hs;
        logic [31:0] rd;
        logic [31:0] exp;
        bit          wr;
        logic [7:0]  a;
        for (int i = 0; i < 300; i++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = 8'($urandom_range(0, 255));
            exp = model[a];
            xfer(wr, a, $urandom, 1'($urandom_range(0, 1)), hs, rd);
            n_checks++;
            if (hs !== 3'b010) begin n_fail++; $display("FAIL rand_hs[%0d]: got %b expected 010", i, hs); end
            if (!wr) begin
                n_checks++;
                if (rd !== exp) begin n_fail++; $display("FAIL rand_rd[%0d] addr %h: got %h expected %h", i, a, rd, exp); end
            end
            if ($urandom_range(0, 3) == 0) step();
        end
        psel = 1'b0; penable = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        logic [2:0]  hs;
        logic [31:0] rd;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 32'hA5A5_A5A5;
        step();
        penable = 1'b1;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (pready !== 1'b0) begin n_fail++; $display("FAIL rstmid_pready: got %b expected 0", pready); end
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
        model_clear();
        step();
        xfer(1'b0, 8'h20, 32'h0, 1'b0, hs, rd);
        n_checks++;
        if (rd !== 32'h0) begin n_fail++; $display("FAIL rstmid_rd20: got %h expected 0", rd); end
        xfer(1'b0, 8'h05, 32'h0, 1'b0, hs, rd);
        n_checks++;
        if (rd !== model[8'h05]) begin n_fail++; $display("FAIL rstmid_rd05: got %h expected %h", rd, model[8'h05]); end
    endtask

    task automatic test_no_setup();
        logic [2:0]  hs;
        logic [31:0] rd;
        xfer(1'b1, 8'h30, 32'h1234_5678, 1'b0, hs, rd);
        step();
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h30; pwdata = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (pready !== 1'b0) begin n_fail++; $display("FAIL nosetup_pready[%0d]: got %b expected 0", i, pready); end
        end
        psel = 1'b0; penable = 1'b0;
        step();
        xfer(1'b0, 8'h30, 32'h0, 1'b0, hs, rd);
        n_checks++;
        if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL nosetup_mem: got %h expected 12345678", rd); end
    endtask

    task automatic test_psel_drop();
        logic [2:0]  hs;
        logic [31:0] rd;
        logic [31:0] old;
        old = model[8'h40];
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h40; pwdata = 32'hCAFE_F00D;
        step();
        psel = 1'b0; penable = 1'b1;
        n_checks++;
        if (pready !== 1'b1) begin n_fail++; $display("FAIL pseldrop_pready: got %b expected 1", pready); end
        step();
        penable = 1'b0;
        step();
        xfer(1'b0, 8'h40, 32'h0, 1'b0, hs, rd);
        n_checks++;
        if (rd !== old) begin n_fail++; $display("FAIL pseldrop_mem: got %h expected %h", rd, old); end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_sweep();
        test_random();
        test_reset_mid();
        test_no_setup();
        test_psel_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
